// File: rtl/counter_pkg.sv
// Shared types for the 4-bit counter sequencer.
// Command opcodes, FSM states and counter geometry.
package counter_pkg;

    localparam int CTR_WIDTH = 4;
    localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

    typedef enum logic [1:0] {
        OP_NOP      = 2'd0,
        OP_LOAD     = 2'd1,
        OP_RUN      = 2'd2,
        OP_LOAD_RUN = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/counter_seq_ctrl.sv
// Command sequencer driving the load/enable counter's control pins.
// Reports the final count and wrap-arounds seen during each command.
module counter_seq_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH  = CTR_WIDTH,
    parameter int STEP_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [WIDTH-1:0]  cmd_value_i,
    input  logic [STEP_W-1:0] cmd_steps_i,
    input  logic              pause_i,
    input  logic [WIDTH-1:0]  ctr_count_i,
    output logic              ctr_load_o,
    output logic              ctr_enable_o,
    output logic [WIDTH-1:0]  ctr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [WIDTH-1:0]  final_count_o,
    output logic [STEP_W-1:0] wrap_cnt_o
);

    state_e            state_q, state_d;
    cmd_op_e           op_q, op_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic [STEP_W-1:0] wrap_q, wrap_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [WIDTH-1:0]  final_q, final_d;
    logic              accept;
    logic              run_en;
    logic              at_max;
    cmd_op_e           op_in;

    assign op_in       = cmd_op_e'(cmd_op_i);
    assign cmd_ready_o = (state_q == ST_IDLE) && !rst_i;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign run_en      = (state_q == ST_RUN) && !pause_i;
    assign at_max      = (ctr_count_i == {WIDTH{1'b1}});

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rem_d   = rem_q;
        wrap_d  = wrap_q;
        data_d  = data_q;
        final_d = final_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d   = op_in;
                    rem_d  = cmd_steps_i;
                    wrap_d = '0;
                    unique case (op_in)
                        OP_LOAD, OP_LOAD_RUN: begin
                            state_d = ST_LOAD;
                            data_d  = cmd_value_i;
                        end
                        OP_RUN: begin
                            state_d = (cmd_steps_i == '0) ? ST_DONE : ST_RUN;
                        end
                        default: state_d = ST_DONE;
                    endcase
                end
            end
            ST_LOAD: begin
                if (op_q == OP_LOAD_RUN && rem_q != '0) state_d = ST_RUN;
                else                                     state_d = ST_DONE;
            end
            ST_RUN: begin
                // Paused cycles neither count down nor sample for wraps.
                if (run_en) begin
                    rem_d = rem_q - 1'b1;
                    if (at_max && wrap_q != '1) wrap_d = wrap_q + 1'b1;
                    if (rem_q == STEP_W'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                final_d = ctr_count_i;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            rem_q   <= '0;
            wrap_q  <= '0;
            data_q  <= '0;
            final_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            wrap_q  <= wrap_d;
            data_q  <= data_d;
            final_q <= final_d;
        end
    end

    assign ctr_load_o    = (state_q == ST_LOAD);
    assign ctr_enable_o  = (state_q == ST_LOAD) || run_en;
    assign ctr_data_o    = data_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_DONE);
    assign final_count_o = final_q;
    assign wrap_cnt_o    = wrap_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl with a behavioural counter and sequencer model.
module tb_counter_seq_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [1:0] cmd_op_i;
    logic [3:0] cmd_value_i;
    logic [7:0] cmd_steps_i;
    logic       pause_i;
    logic [3:0] ctr_count_i;
    logic       ctr_load_o;
    logic       ctr_enable_o;
    logic [3:0] ctr_data_o;
    logic       busy_o;
    logic       done_o;
    logic [3:0] final_count_o;
    logic [7:0] wrap_cnt_o;

    int checks = 0;
    int fails  = 0;

    counter_seq_ctrl #(.WIDTH(4), .STEP_W(8)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_op_i      (cmd_op_i),
        .cmd_value_i   (cmd_value_i),
        .cmd_steps_i   (cmd_steps_i),
        .pause_i       (pause_i),
        .ctr_count_i   (ctr_count_i),
        .ctr_load_o    (ctr_load_o),
        .ctr_enable_o  (ctr_enable_o),
        .ctr_data_o    (ctr_data_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .final_count_o (final_count_o),
        .wrap_cnt_o    (wrap_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // The 4-bit load/enable counter the sequencer controls.
    logic [3:0] ctr = '0;
    assign ctr_count_i = ctr;
    always @(posedge clk_i) begin
        if (rst_i)                           ctr <= '0;
        else if (ctr_load_o && ctr_enable_o) ctr <= ctr_data_o;
        else if (ctr_enable_o)               ctr <= ctr + 4'd1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Model: a command is a pending load, a number of enabled steps, then a done beat.
    bit       m_idle;
    bit       m_load;
    int       m_steps;
    int       m_data;
    int       m_final;
    int       m_wrap;

    initial begin
        bit e_load, e_run, e_done, e_en;
        m_idle = 1; m_load = 0; m_steps = 0;
        m_data = 0; m_final = 0; m_wrap = 0;
        @(posedge clk_i);
        forever begin
            @(negedge clk_i);
            e_load = !m_idle && m_load;
            e_run  = !m_idle && !m_load && m_steps > 0;
            e_done = !m_idle && !m_load && m_steps == 0;
            e_en   = e_load || (e_run && !pause_i);
            chk("ready",  int'(cmd_ready_o),   int'(m_idle && !rst_i));
            chk("busy",   int'(busy_o),        int'(!m_idle));
            chk("load",   int'(ctr_load_o),    int'(e_load));
            chk("enable", int'(ctr_enable_o),  int'(e_en));
            chk("data",   int'(ctr_data_o),    m_data);
            chk("done",   int'(done_o),        int'(e_done));
            chk("final",  int'(final_count_o), m_final);
            chk("wrap",   int'(wrap_cnt_o),    m_wrap);
            if (rst_i) begin
                m_idle = 1; m_load = 0; m_steps = 0;
                m_data = 0; m_final = 0; m_wrap = 0;
            end else if (m_idle) begin
                if (cmd_valid_i) begin
                    m_idle  = 0;
                    m_wrap  = 0;
                    m_load  = cmd_op_i[0];
                    m_steps = cmd_op_i[1] ? int'(cmd_steps_i) : 0;
                    if (cmd_op_i[0]) m_data = int'(cmd_value_i);
                end
            end else if (e_load) begin
                m_load = 0;
            end else if (e_run) begin
                if (!pause_i) begin
                    if (ctr == 4'hF && m_wrap < 255) m_wrap++;
                    m_steps--;
                end
            end else begin
                m_final = int'(ctr);
                m_idle  = 1;
            end
        end
    end

    // Issue one command from an idle cycle; returns one cycle after done.
    task automatic run_cmd(input int op, input int val, input int st,
                           input int ps, input int pl, input int exp_done,
                           input int exp_final, input int exp_wrap,
                           input int exp_en);
        int c;
        int en_n;
        bit seen;
        cmd_valid_i = 1'b1;
        cmd_op_i    = 2'(op);
        cmd_value_i = 4'(val);
        cmd_steps_i = 8'(st);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        cmd_op_i    = 2'($urandom);
        cmd_value_i = 4'($urandom);
        cmd_steps_i = 8'($urandom);
        c = 1; en_n = 0; seen = 0;
        while (!seen && c < 100) begin
            pause_i = (c >= ps) && (c < ps + pl);
            @(negedge clk_i);
            if (ctr_enable_o) en_n++;
            if (done_o) seen = 1;
            else begin
                @(posedge clk_i); #1;
                c++;
            end
        end
        pause_i = 1'b0;
        chk("done_cycle", c, exp_done);
        chk("enables", en_n, exp_en);
        @(posedge clk_i); #1;
        chk("final_lit", int'(final_count_o), exp_final);
        chk("wrap_lit", int'(wrap_cnt_o), exp_wrap);
    endtask

    initial begin
        int acc[2];
        int dn[2];
        int na;
        int nd;
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = '0;
        cmd_value_i = '0; cmd_steps_i = '0; pause_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_ready", int'(cmd_ready_o), 1);
        chk("rst_final", int'(final_count_o), 0);
        @(posedge clk_i); #1;

        run_cmd(3, 14, 5, 0, 0, 7, 3, 1, 6);
        run_cmd(1, 9, 0, 0, 0, 2, 9, 0, 1);
        run_cmd(0, 3, 7, 0, 0, 1, 9, 0, 0);
        run_cmd(1, 6, 0, 0, 0, 2, 6, 0, 1);
        run_cmd(2, 0, 0, 0, 0, 1, 6, 0, 0);
        run_cmd(1, 0, 0, 0, 0, 2, 0, 0, 1);
        run_cmd(2, 0, 4, 3, 3, 8, 4, 0, 4);
        run_cmd(3, 15, 17, 0, 0, 19, 0, 2, 18);

        // Abort a long LOAD_RUN with a reset in its tenth RUN cycle.
        cmd_valid_i = 1'b1; cmd_op_i = 2'd3;
        cmd_value_i = 4'd0; cmd_steps_i = 8'd40;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_en", int'(ctr_enable_o), 0);
        chk("abort_wrap", int'(wrap_cnt_o), 0);
        chk("abort_ready", int'(cmd_ready_o), 1);
        nd = 0;
        repeat (4) begin
            @(negedge clk_i);
            if (done_o) nd++;
        end
        chk("abort_no_done", nd, 0);
        @(posedge clk_i); #1;

        // Two RUN commands with valid held throughout.
        cmd_valid_i = 1'b1; cmd_op_i = 2'd2;
        cmd_value_i = 4'd0; cmd_steps_i = 8'd2;
        na = 0; nd = 0;
        acc = '{-1, -1}; dn = '{-1, -1};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            if (cmd_ready_o && na < 2) begin acc[na] = c; na++; end
            if (done_o && nd < 2) begin dn[nd] = c; nd++; end
            @(posedge clk_i); #1;
        end
        cmd_valid_i = 1'b0;
        chk("b2b_acc0", acc[0], 0);
        chk("b2b_acc1", acc[1], 4);
        chk("b2b_done0", dn[0], 3);
        chk("b2b_done1", dn[1], 7);
        repeat (2) @(posedge clk_i);
        #1;
        chk("b2b_final", int'(final_count_o), 4);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
